// File: rtl/vaccum_scan_display.sv
// vaccum_scan_display: nibble accumulator with sticky overflow driving a
// time-multiplexed common-anode 7-segment display.
module vaccum_scan_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                add_en,
    input  logic [3:0]          operand,
    output logic [4*DIGITS-1:0] acc,
    output logic                oflow,
    output logic [6:0]          seg_L,
    output logic                dp_L,
    output logic [DIGITS-1:0]   an_L
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [PW-1:0] pre;
    logic [IW-1:0] idx;
    logic [W:0]    sum;
    logic          wrap;
    logic          blank;
    logic [3:0]    nib;
    int            sh;

    assign sum  = {1'b0, acc} + (W + 1)'(operand);
    assign wrap = pre == PW'(REFRESH_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre   <= '0;
            idx   <= '0;
            acc   <= '0;
            oflow <= 1'b0;
        end else begin
            pre <= wrap ? '0 : pre + 1'b1;
            if (wrap)
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            if (clr) begin
                acc   <= '0;
                oflow <= 1'b0;
            end else if (add_en) begin
                acc   <= sum[W-1:0];
                oflow <= oflow | sum[W];
            end
        end
    end

    // Leading-zero blanking: a digit is blank when it and every higher digit are zero.
    always_comb begin
        sh    = 4 * int'(idx);
        nib   = acc[sh +: 4];
        blank = (BLANK_LZ != 0) && (idx != '0) && ((acc >> sh) == '0);
        seg_L = blank ? 7'h7F : SEG[nib];
        dp_L  = !(oflow && idx == IW'(DIGITS - 1));
        an_L  = ~(DIGITS'(1) << idx);
    end
endmodule

// File: tb/tb_vaccum_scan_display.sv
// tb_vaccum_scan_display: table vectors, corner sequences and random stimulus
// against an arithmetic reference model; two DUTs cover both blanking modes.
module tb_vaccum_scan_display;
    logic        clk = 1'b0;
    logic        rst_n, clr, add_en;
    logic [3:0]  operand;
    logic [15:0] acc1, acc0;
    logic        of1, of0, dp1, dp0;
    logic [6:0]  seg1, seg0;
    logic [3:0]  an1, an0;
    int          checks = 0, failures = 0;
    int          acc_m, n_m;
    bit          of_m;

    localparam logic [6:0] TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic        c, a;
        logic [3:0]  op;
        logic [15:0] e_acc;
        logic        e_of;
    } vec_t;
    vec_t vecs [9];

    vaccum_scan_display #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .add_en(add_en), .operand(operand),
        .acc(acc1), .oflow(of1), .seg_L(seg1), .dp_L(dp1), .an_L(an1));
    vaccum_scan_display #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .add_en(add_en), .operand(operand),
        .acc(acc0), .oflow(of0), .seg_L(seg0), .dp_L(dp0), .an_L(an0));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        int id, nib;
        bit bl;
        id  = (n_m / 4) % 4;
        nib = (acc_m >> (4 * id)) & 15;
        bl  = id > 0 && (acc_m >> (4 * id)) == 0;
        chk("acc", 32'(acc1), 32'(acc_m));
        chk("oflow", 32'(of1), 32'(of_m));
        chk("an", 32'(an1), 32'(4'hF & ~(4'h1 << id)));
        chk("seg_blank", 32'(seg1), 32'(bl ? 7'h7F : TAB[nib]));
        chk("seg_full", 32'(seg0), 32'(TAB[nib]));
        chk("dp", 32'(dp1), 32'(!(of_m && id == 3)));
        chk("pair", 32'({acc0, of0, an0, dp0}), 32'({acc1, of1, an1, dp1}));
    endtask

    task automatic tick(input logic c, input logic a, input logic [3:0] op);
        int s;
        clr = c; add_en = a; operand = op;
        @(posedge clk);
        #1;
        n_m++;
        if (c) begin
            acc_m = 0; of_m = 0;
        end else if (a) begin
            s = acc_m + int'(op);
            if (s > 65535) of_m = 1;
            acc_m = s % 65536;
        end
        clr = 0; add_en = 0; operand = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_acc"}, 32'(acc1), 0);
        chk({tag, "_of"}, 32'(of1), 0);
        chk({tag, "_an"}, 32'(an1), 32'h0E);
        chk({tag, "_seg"}, 32'(seg1), 32'h40);
        chk({tag, "_dp"}, 32'(dp1), 1);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 4'h9, 16'h0009, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 4'h8, 16'h0011, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 4'h7, 16'h0011, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 4'h5, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 4'hF, 16'h000F, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 4'hF, 16'h001E, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 4'hF, 16'h002D, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 4'hF, 16'h003C, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 4'hF, 16'h004B, 1'b0};
        rst_n = 0; clr = 0; add_en = 0; operand = 0;
        acc_m = 0; of_m = 0; n_m = 0;
        #3 check_reset("rst_hold");
        #9 rst_n = 1;
        check_reset("rst_rel");
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0);
            check_model();
        end
        for (int i = 0; i < 9; i++) begin
            tick(vecs[i].c, vecs[i].a, vecs[i].op);
            chk("vec_acc", 32'(acc1), 32'(vecs[i].e_acc));
            chk("vec_of", 32'(of1), 32'(vecs[i].e_of));
            check_model();
        end
        for (int i = 0; i < 16; i++) begin
            tick(0, 0, 0);
            check_model();
            if (an0 == 4'b0111) chk("lz0_d3", 32'(seg0), 32'h40);
            if (an0 == 4'b1011) chk("lz0_d2", 32'(seg0), 32'h40);
            if (an0 == 4'b1101) chk("lz0_d1", 32'(seg0), 32'h19);
            if (an0 == 4'b1110) chk("lz0_d0", 32'(seg0), 32'h03);
        end
        tick(1, 0, 0);
        for (int i = 0; i < 4368; i++) tick(0, 1, 4'hF);
        tick(0, 1, 4'hE);
        chk("preload", 32'(acc1), 32'hFFFE);
        chk("preload_of", 32'(of1), 0);
        tick(0, 1, 4'h3);
        chk("wrap_acc", 32'(acc1), 32'h0001);
        chk("wrap_of", 32'(of1), 1);
        check_model();
        tick(0, 1, 4'h1);
        chk("sticky_of", 32'(of1), 1);
        for (int i = 0; i < 16; i++) begin
            tick(0, 0, 0);
            check_model();
            chk("dp_digit3", 32'(dp1), 32'(an1 != 4'b0111));
        end
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(15) == 0), $urandom_range(1), 4'($urandom_range(15)));
            check_model();
        end
        for (int i = 0; i < 40 && !(((n_m / 4) % 4) != 0 && acc_m != 0 && (n_m % 4) != 0); i++)
            tick(0, 1, 4'($urandom_range(1, 15)));
        chk("prereset_idx", 32'(an1 != 4'b1110), 1);
        @(negedge clk);
        rst_n = 0;
        #1 check_reset("async");
        @(negedge clk);
        rst_n = 1;
        acc_m = 0; of_m = 0; n_m = 0;
        check_reset("post");
        for (int i = 0; i < 12; i++) begin
            tick(0, 1, 4'($urandom_range(15)));
            check_model();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
